// File: rtl/multadd_pipe.sv
// multadd_pipe: pipelined signed fixed-point y = ((x1*x2) >>> FRAC) + (acc_mode ? y : x3)
// with valid/ready flow control. Define MULTADD_SAT_EN to clamp y on overflow (default wraps).
module multadd_pipe #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] x2,
  input  logic signed [WIDTH-1:0] x3,
  input  logic                    acc_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);

  localparam int PROD_W = 2 * WIDTH;
  // Wide enough for any legal FRAC, so the range test never sees a wrapped sum.
  localparam int SUM_W  = PROD_W + 1;

  function automatic logic range_ovf(input logic signed [SUM_W-1:0] s);
    return !((&s[SUM_W-1:WIDTH-1]) || !(|s[SUM_W-1:WIDTH-1]));
  endfunction

  function automatic logic signed [WIDTH-1:0] fit_result(input logic signed [SUM_W-1:0] s);
`ifdef MULTADD_SAT_EN
    if (range_ovf(s))
      return s[SUM_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return s[WIDTH-1:0];
  endfunction

  logic                     en;
  logic                     vld_p0, vld_p1, vld_p2;
  logic signed [WIDTH-1:0]  x1_p0, x2_p0, x3_p0, x3_p1;
  logic                     acc_p0, acc_p1;
  logic signed [PROD_W-1:0] x1_ext, x2_ext, prod_full, prod_p1;
  logic signed [WIDTH-1:0]  addend;
  logic signed [SUM_W-1:0]  prod_ext, addend_ext, sum;
  logic signed [WIDTH-1:0]  y_p2;
  logic                     ovf_p2;

  assign en        = !vld_p2 || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;
  assign y         = y_p2;
  assign ovf       = ovf_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- S1: operand register ----
  always_ff @(posedge clk) begin
    if (en) begin
      x1_p0  <= x1;
      x2_p0  <= x2;
      x3_p0  <= x3;
      acc_p0 <= acc_mode;
    end
  end

  // ---- S2: scaled product register ----
  assign x1_ext    = {{WIDTH{x1_p0[WIDTH-1]}}, x1_p0};
  assign x2_ext    = {{WIDTH{x2_p0[WIDTH-1]}}, x2_p0};
  assign prod_full = (x1_ext * x2_ext) >>> FRAC;

  always_ff @(posedge clk) begin
    if (en) begin
      prod_p1 <= prod_full;
      x3_p1   <= x3_p0;
      acc_p1  <= acc_p0;
    end
  end

  // ---- S3: add, range check, output register ----
  assign addend     = acc_p1 ? y_p2 : x3_p1;
  assign prod_ext   = {prod_p1[PROD_W-1], prod_p1};
  assign addend_ext = {{(SUM_W-WIDTH){addend[WIDTH-1]}}, addend};
  assign sum        = prod_ext + addend_ext;

  // A bubble leaves y/ovf alone so the accumulate history survives idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_p2   <= '0;
      ovf_p2 <= 1'b0;
    end else if (en && vld_p1) begin
      y_p2   <= fit_result(sum);
      ovf_p2 <= range_ovf(sum);
    end
  end

endmodule

// File: tb/tb_multadd_pipe.sv
// Self-checking bench for multadd_pipe (WIDTH=10, FRAC=9): vector table, scoreboard,
// latency, accumulate, backpressure and asynchronous reset sequences.
module tb_multadd_pipe;
  localparam int W = 10;
  localparam int F = 9;

`ifdef MULTADD_SAT_EN
  localparam logic [W-1:0] OV3 = 10'h1FF, OV5 = 10'h1FF, OV6 = 10'h200, ACC4 = 10'h1FF;
`else
  localparam logic [W-1:0] OV3 = 10'h3FF, OV5 = 10'h270, OV6 = 10'h180, ACC4 = 10'h200;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x1 = '0, x2 = '0, x3 = '0;
  logic         acc_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] y;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] x1, x2, x3;
    logic         acc;
    logic [W-1:0] ey;
    logic         eovf;
  } vec_t;

  res_t         sb[$];
  logic [W-1:0] model_y = '0;
  int           ntests = 0;
  int           nfail = 0;
  int           cyc = 0;
  vec_t         vecs[9];

  multadd_pipe #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .x3(x3), .acc_mode(acc_mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic res_t mk(input logic [W-1:0] yy, input logic oo);
    res_t r;
    r.y = yy;
    r.ovf = oo;
    return r;
  endfunction

  function automatic res_t model(input logic [W-1:0] a, b, c, input logic acc,
                                 input logic [W-1:0] prev);
    longint pa = longint'($signed(a));
    longint pb = longint'($signed(b));
    longint pc = longint'($signed(c));
    longint pp = longint'($signed(prev));
    longint hi = (longint'(1) <<< (W - 1)) - 1;
    longint lo = -(longint'(1) <<< (W - 1));
    longint s;
    res_t r;
    s = ((pa * pb) >>> F) + (acc ? pp : pc);
    r.ovf = (s > hi) || (s < lo);
`ifdef MULTADD_SAT_EN
    r.y = (s > hi) ? W'(hi) : (s < lo) ? W'(lo) : W'(s);
`else
    r.y = W'(s);
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [W-1:0] a, b, c, input logic acc, input res_t exp);
    int waited = 0;
    x1 = a; x2 = b; x3 = c; acc_mode = acc; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      sb.push_back(exp);
      model_y = exp.y;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] a, b, c, input logic acc);
    send(a, b, c, acc, model(a, b, c, acc, model_y));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: handshake rule and in-order scoreboard.
  always @(negedge clk) begin : monitor
    res_t e;
    if (reset_n) begin
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_output: got y=%0h ovf=%0b, expected no result", y, ovf);
        end else begin
          e = sb.pop_front();
          check("y", 32'(y), 32'(e.y));
          check("ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    int t0;
    vecs[0] = '{10'h100, 10'h100, 10'h000, 1'b0, 10'h080, 1'b0};
    vecs[1] = '{10'h3FF, 10'h001, 10'h000, 1'b0, 10'h3FF, 1'b0};
    vecs[2] = '{10'h200, 10'h200, 10'h1FF, 1'b0, OV3,     1'b1};
    vecs[3] = '{10'h200, 10'h1FF, 10'h000, 1'b0, 10'h201, 1'b0};
    vecs[4] = '{10'h100, 10'h100, 10'h1F0, 1'b0, OV5,     1'b1};
    vecs[5] = '{10'h300, 10'h100, 10'h200, 1'b0, OV6,     1'b1};
    vecs[6] = '{10'h0FF, 10'h0FF, 10'h001, 1'b0, 10'h080, 1'b0};
    vecs[7] = '{10'h3FF, 10'h3FF, 10'h000, 1'b0, 10'h000, 1'b0};
    vecs[8] = '{10'h001, 10'h3FE, 10'h000, 1'b0, 10'h3FF, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accept on edge N, out_valid after edge N+2
    send(10'h100, 10'h100, 10'h000, 1'b0, mk(10'h080, 1'b0));
    @(negedge clk);
    check("lat_after_N", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_after_N1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_after_N2", 32'(out_valid), 32'd1);
    check("lat_y", 32'(y), 32'h080);
    @(posedge clk);
    #1;

    // Vector table, back-to-back
    foreach (vecs[i]) send(vecs[i].x1, vecs[i].x2, vecs[i].x3, vecs[i].acc,
                           mk(vecs[i].ey, vecs[i].eovf));
    drain("drain_table");

    // 20 random beats at full rate
    t0 = cyc;
    for (int i = 0; i < 20; i++)
      send_model(W'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
    check("throughput_edges", 32'(cyc - t0), 32'd20);
    drain("drain_random");

    // Accumulate, back-to-back
    send(10'h100, 10'h100, 10'h000, 1'b0, mk(10'h080, 1'b0));
    send(10'h100, 10'h100, 10'h155, 1'b1, mk(10'h100, 1'b0));
    send(10'h100, 10'h100, 10'h2AA, 1'b1, mk(10'h180, 1'b0));
    send(10'h100, 10'h100, 10'h000, 1'b1, mk(ACC4, 1'b1));
    drain("drain_acc");

    // Accumulate with an idle cycle between beats
    send(10'h100, 10'h100, 10'h000, 1'b0, mk(10'h080, 1'b0));
    @(posedge clk); #1;
    send(10'h100, 10'h100, 10'h155, 1'b1, mk(10'h100, 1'b0));
    @(posedge clk); #1;
    send(10'h100, 10'h100, 10'h2AA, 1'b1, mk(10'h180, 1'b0));
    @(posedge clk); #1;
    send(10'h100, 10'h100, 10'h000, 1'b1, mk(ACC4, 1'b1));
    drain("drain_acc_idle");

    // Backpressure: 8 beats, out_ready low for 4 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_model(W'($urandom), W'($urandom), W'($urandom), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
      end
    join
    drain("drain_bp");

    // Asynchronous reset with two beats in flight
    send_model(10'h100, 10'h100, 10'h050, 1'b0);
    send_model(10'h100, 10'h100, 10'h000, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    model_y = '0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(10'h100, 10'h100, 10'h055, 1'b1, mk(10'h080, 1'b0));
    drain("drain_after_rst");
    check("no_extra_out", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
